zigzag_kodlayici: RTL and testbench
===================================

# zigzag_kodlayici

Encoder-side counterpart of the zigzag normalizer. Collects one 8x8 block of quantized coefficients addressed by row/col, scans it in JPEG zigzag order and emits (run, value) pairs with ZRL and EOB symbols. It sits in the JPEG encoder path between the quantizer and the Huffman encoder.

## Interface
- VERI_BIT, 12: signed coefficient width (two's complement).
- RUN_BIT, 4: run-length width.
- BLOCK_BIT, 3: row/col index width.
- clk_i  input  1  clock; all state changes on rising edge.
- rstn_i  input  1  reset; asynchronous, active-low.
- q_veri_i  input  VERI_BIT  quantized coefficient.
- q_row_i / q_col_i  input  BLOCK_BIT each  coefficient position.
- q_gecerli_i  input  1  input beat valid.
- q_blok_son_i  input  1  last beat of block; qualified by q_gecerli_i.
- q_hazir_o  output  1  input ready.
- hk_run_o  output  RUN_BIT  zero run preceding value.
- hk_veri_o  output  VERI_BIT  coefficient value (0 for ZRL/EOB).
- hk_gecerli_o  output  1  output pair valid.
- hk_blk_son_o  output  1  final pair of block.
- hk_hazir_i  input  1  downstream ready.

## Operation
- States: YAZ (fill), TARA (scan). Reset enters YAZ.
- YAZ: q_hazir_o=1. Each handshake (q_gecerli_i & q_hazir_o) writes q_veri_i to buffer address row*8+col, and sets/clears bit zigzag(row,col) of a 64-bit nonzero mask (set iff value != 0, full width). Repeated writes to a position overwrite it. Unwritten positions count as zero; the buffer is never cleared, only the mask.
- Handshake with q_blok_son_i=1 writes its data, then moves to TARA. L = highest set mask index in 1..63, or 0 if none.
- TARA: q_hazir_o=0. Index k steps 0..L through a zigzag->raster table, one position per cycle when the output register can load. A position whose mask bit is 0 is zero.
- k=0: always emit (0, DC), including DC=0.
- k=1..L, run counter r starts at 0:
  - Zero and r<15: r++, no output.
  - Zero and r=15: emit ZRL (15, 0), r=0.
  - Nonzero: emit (r, value), r=0.
- After k=L:
  - L<63: emit EOB (0, 0, blk_son=1).
  - L=63: the pair for k=63 carries blk_son=1 and no EOB follows.
  - L=0: DC is followed directly by EOB.
- Handshake of the blk_son pair clears the mask and returns to YAZ.
- ZRL is never emitted after the last nonzero coefficient, because the scan stops at L.

## Timing
- Reset values: hk_gecerli_o=0, hk_run_o=0, hk_veri_o=0, hk_blk_son_o=0, state YAZ, mask all zeros, q_hazir_o=1 once rstn_i is high.
- Output register loads when !hk_gecerli_o | hk_hazir_i. While hk_gecerli_o & !hk_hazir_i, all hk_* outputs hold stable and the scan pauses.
- Let N be the edge accepting q_blok_son_i:
  - Edge N+1: TARA entered, L latched, q_hazir_o low.
  - Edge N+2: DC pair valid.
- With hk_hazir_i held at 1, each index k=1..L takes one cycle. The EOB pair is valid at edge N+3+L. For L=63, the final pair is valid at edge N+65.
- Cycles in which a zero is absorbed drop hk_gecerli_o if the previous pair has been taken.
- q_hazir_o returns high the cycle after the blk_son handshake. There is no overlap between blocks.
- Reset asserted mid-block or mid-scan:
  - All outputs clear immediately.
  - The aborted block is discarded.
  - The next block is unaffected, because the mask is cleared.

## Test plan
- DC=-5 only, all else unwritten -> (0,-5), (0,0,son); 2 beats; EOB at N+3.
- raster(0,1)=3 [zz1], raster(2,0)=-1 [zz3], DC=10 -> (0,10), (0,3), (1,-1), (0,0,son).
- Only zz40 = 7, DC=0 -> (0,0), (15,0) at k=16, (15,0) at k=32, (7,7), (0,0,son).
- Only raster(7,7)=1 [zz63], DC=2 -> (0,2), three (15,0), then (14,1) with son=1; no EOB; last pair at N+65.
- Case 2 with hk_hazir_i toggling every cycle -> identical pair sequence; outputs stable while stalled; q_hazir_o low until the final handshake.
- rstn_i low for 1 cycle mid-scan of case 3 -> outputs 0 asynchronously. A following case-2 block yields exactly the case-2 sequence with no stale values.

Source files
------------

// File: rtl/zigzag_kodlayici.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_kodlayici
// Purpose  : Collects one 8x8 block of quantized coefficients addressed by
//            row/col. The block is scanned in JPEG zigzag order and emitted as
//            (run, value) pairs, with ZRL (15,0) and EOB (0,0) symbols.
//            This block sits between the quantizer and the Huffman encoder.
// Ports    : clk_i, rstn_i        clock, asynchronous active-low reset
//            q_veri_i/q_row_i/q_col_i, q_gecerli_i, q_blok_son_i, q_hazir_o
//                                 coefficient input beat with valid/ready
//            hk_run_o/hk_veri_o/hk_blk_son_o, hk_gecerli_o, hk_hazir_i
//                                 (run, value) pair output with valid/ready
// Revision : 1.0 - initial release
// ============================================================================
module zigzag_kodlayici #(
    parameter int VERI_BIT  = 12,
    parameter int RUN_BIT   = 4,
    parameter int BLOCK_BIT = 3
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [VERI_BIT-1:0]  q_veri_i,
    input  logic [BLOCK_BIT-1:0] q_row_i,
    input  logic [BLOCK_BIT-1:0] q_col_i,
    input  logic                 q_gecerli_i,
    input  logic                 q_blok_son_i,
    output logic                 q_hazir_o,
    output logic [RUN_BIT-1:0]   hk_run_o,
    output logic [VERI_BIT-1:0]  hk_veri_o,
    output logic                 hk_gecerli_o,
    output logic                 hk_blk_son_o,
    input  logic                 hk_hazir_i
);

    // YAZ fills the block, KILIT latches the last nonzero index, TARA scans.
    localparam logic [1:0]         c_YAZ     = 2'd0;
    localparam logic [1:0]         c_KILIT   = 2'd1;
    localparam logic [1:0]         c_TARA    = 2'd2;
    localparam logic [RUN_BIT-1:0] c_RUN_MAX = {RUN_BIT{1'b1}};
    localparam logic [RUN_BIT-1:0] c_RUN_BIR = {{(RUN_BIT-1){1'b0}}, 1'b1};

    // Zigzag index of (row, col): anti-diagonal d = row+col starts at a
    // triangular base; odd diagonals run downward (row increasing), even
    // diagonals run upward (row decreasing).
    function automatic logic [5:0] f_zigzag(input logic [BLOCK_BIT-1:0] row,
                                            input logic [BLOCK_BIT-1:0] col);
        logic [7:0] r8, c8, d, taban, ofs;
        r8 = 8'(row);
        c8 = 8'(col);
        d  = r8 + c8;
        if (d < 8'd8) begin
            taban = (d * (d + 8'd1)) >> 1;
            ofs   = d[0] ? r8 : c8;
        end else begin
            taban = 8'd64 - (((8'd15 - d) * (8'd16 - d)) >> 1);
            ofs   = d[0] ? (r8 - (d - 8'd7)) : (8'd7 - r8);
        end
        f_zigzag = 6'(taban + ofs);
    endfunction

    logic [1:0]          r_durum;
    logic [63:0]         r_mask;
    logic [VERI_BIT-1:0] r_buf [0:63];
    logic [5:0]          r_k;
    logic [5:0]          r_son_k;
    logic [RUN_BIT-1:0]  r_run;
    logic                r_eob;
    logic                r_son_gitti;
    logic [RUN_BIT-1:0]  r_hk_run;
    logic [VERI_BIT-1:0] r_hk_veri;
    logic                r_hk_gecerli;
    logic                r_hk_son;

    logic                w_yaz_hs;
    logic [5:0]          w_zz;
    logic [5:0]          w_son_idx;
    logic                w_load;
    logic                w_nz;
    logic [VERI_BIT-1:0] w_deger;

    assign w_yaz_hs = q_gecerli_i & (r_durum == c_YAZ);
    assign w_zz     = f_zigzag(q_row_i, q_col_i);
    assign w_load   = ~r_hk_gecerli | hk_hazir_i;
    assign w_nz     = r_mask[r_k];
    assign w_deger  = w_nz ? r_buf[r_k] : '0;

    // Highest set mask index among AC positions; 0 when only DC (or nothing).
    always_comb begin
        w_son_idx = '0;
        for (int i = 1; i < 64; i++) begin
            if (r_mask[i]) w_son_idx = 6'(i);
        end
    end

    // The buffer is held in scan order so the scan reads it by k directly.
    // It is never cleared: the mask alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_yaz_hs) r_buf[w_zz] <= q_veri_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_durum      <= c_YAZ;
            r_mask       <= '0;
            r_k          <= '0;
            r_son_k      <= '0;
            r_run        <= '0;
            r_eob        <= 1'b0;
            r_son_gitti  <= 1'b0;
            r_hk_run     <= '0;
            r_hk_veri    <= '0;
            r_hk_gecerli <= 1'b0;
            r_hk_son     <= 1'b0;
        end else begin
            case (r_durum)
                c_YAZ: begin
                    if (w_yaz_hs) begin
                        r_mask[w_zz] <= (q_veri_i != '0);
                        if (q_blok_son_i) r_durum <= c_KILIT;
                    end
                end
                c_KILIT: begin
                    r_son_k     <= w_son_idx;
                    r_k         <= '0;
                    r_run       <= '0;
                    r_eob       <= 1'b0;
                    r_son_gitti <= 1'b0;
                    r_durum     <= c_TARA;
                end
                c_TARA: begin
                    if (w_load) begin
                        if (r_son_gitti) begin
                            // Loading while the blk_son pair is valid means
                            // it was just taken: the block is finished.
                            r_hk_gecerli <= 1'b0;
                            r_hk_son     <= 1'b0;
                            r_hk_run     <= '0;
                            r_hk_veri    <= '0;
                            r_mask       <= '0;
                            r_durum      <= c_YAZ;
                        end else if (r_eob) begin
                            r_hk_run     <= '0;
                            r_hk_veri    <= '0;
                            r_hk_son     <= 1'b1;
                            r_hk_gecerli <= 1'b1;
                            r_son_gitti  <= 1'b1;
                        end else begin
                            if (r_k == 6'd0) begin
                                // DC is always emitted, even when zero.
                                r_hk_run     <= '0;
                                r_hk_veri    <= w_deger;
                                r_hk_son     <= 1'b0;
                                r_hk_gecerli <= 1'b1;
                            end else if (w_nz) begin
                                r_hk_run     <= r_run;
                                r_hk_veri    <= w_deger;
                                r_hk_son     <= (r_k == 6'd63);
                                r_hk_gecerli <= 1'b1;
                                r_run        <= '0;
                            end else if (r_run == c_RUN_MAX) begin
                                r_hk_run     <= c_RUN_MAX;
                                r_hk_veri    <= '0;
                                r_hk_son     <= 1'b0;
                                r_hk_gecerli <= 1'b1;
                                r_run        <= '0;
                            end else begin
                                r_run        <= r_run + c_RUN_BIR;
                                r_hk_gecerli <= 1'b0;
                            end
                            // A pair at k=63 already ends the block; any
                            // earlier end index is followed by an EOB.
                            if (r_k == r_son_k) begin
                                if (r_k == 6'd63) r_son_gitti <= 1'b1;
                                else              r_eob       <= 1'b1;
                            end else begin
                                r_k <= r_k + 6'd1;
                            end
                        end
                    end
                end
                default: r_durum <= c_YAZ;
            endcase
        end
    end

    // Held low while reset is asserted so no beat is accepted during reset.
    assign q_hazir_o    = rstn_i & (r_durum == c_YAZ);
    assign hk_run_o     = r_hk_run;
    assign hk_veri_o    = r_hk_veri;
    assign hk_gecerli_o = r_hk_gecerli;
    assign hk_blk_son_o = r_hk_son;

endmodule
`default_nettype wire

// File: tb/tb_zigzag_kodlayici.sv
`default_nettype none
// ============================================================================
// Module   : tb_zigzag_kodlayici
// Purpose  : Scoreboard bench for zigzag_kodlayici. Blocks are described as
//            lists of (row, col, value) beats; a raster-domain model builds
//            the expected (run, value, son) pair list and a monitor compares
//            every handshaken output pair against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zigzag_kodlayici;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [11:0] q_veri_i = '0;
    logic [2:0]  q_row_i = '0;
    logic [2:0]  q_col_i = '0;
    logic        q_gecerli_i = 1'b0;
    logic        q_blok_son_i = 1'b0;
    logic        q_hazir_o;
    logic [3:0]  hk_run_o;
    logic [11:0] hk_veri_o;
    logic        hk_gecerli_o;
    logic        hk_blk_son_o;
    logic        hk_hazir_i = 1'b1;

    zigzag_kodlayici #(.VERI_BIT(12), .RUN_BIT(4), .BLOCK_BIT(3)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .q_veri_i(q_veri_i), .q_row_i(q_row_i), .q_col_i(q_col_i),
        .q_gecerli_i(q_gecerli_i), .q_blok_son_i(q_blok_son_i),
        .q_hazir_o(q_hazir_o),
        .hk_run_o(hk_run_o), .hk_veri_o(hk_veri_o),
        .hk_gecerli_o(hk_gecerli_o), .hk_blk_son_o(hk_blk_son_o),
        .hk_hazir_i(hk_hazir_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [3:0] run; logic [11:0] veri; logic son; } pair_t;
    typedef struct packed { logic [2:0] row; logic [2:0] col; logic [11:0] veri; } beat_t;

    pair_t       exp_q[$];
    beat_t       beats_q[$];
    int          order[64];
    logic [11:0] vals[64];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_edge = 0;
    int          exp_L = 0;
    int          stall_mode = 0;
    bit          timing_chk = 0;
    bit          busy = 0;
    bit          clr_pending = 0;
    bit          mon_en = 0;
    bit          prev_stalled = 0;
    pair_t       saved;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #1;
        case (stall_mode)
            0:       hk_hazir_i = 1'b1;
            1:       hk_hazir_i = ~hk_hazir_i;
            default: hk_hazir_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic pair_t mk(input logic [3:0] run, input logic [11:0] v, input logic son);
        pair_t p;
        p.run = run; p.veri = v; p.son = son;
        return p;
    endfunction

    // Monitor: compares each output pair as it is handshaken.
    always @(negedge clk_i) begin
        if (mon_en && rstn_i) begin
            pair_t e;
            if (clr_pending) begin busy = 0; clr_pending = 0; end
            chk("q_hazir", {31'd0, q_hazir_o}, {31'd0, !busy});
            if (prev_stalled)
                chk("stall_hold", {15'd0, hk_gecerli_o, hk_run_o, hk_veri_o, hk_blk_son_o},
                    {15'd0, 1'b1, saved.run, saved.veri, saved.son});
            if (hk_gecerli_o && hk_hazir_i) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pair: got run %0d veri %0h son %0b, none expected",
                             hk_run_o, hk_veri_o, hk_blk_son_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_run", {28'd0, hk_run_o}, {28'd0, e.run});
                    chk("pair_veri", {20'd0, hk_veri_o}, {20'd0, e.veri});
                    chk("pair_son", {31'd0, hk_blk_son_o}, {31'd0, e.son});
                    if (e.son) begin
                        clr_pending = 1;
                        if (timing_chk)
                            chk("son_edge", cyc - n_edge, (exp_L == 63) ? 65 : 3 + exp_L);
                    end
                end
            end
            prev_stalled = hk_gecerli_o && !hk_hazir_i;
            saved = mk(hk_run_o, hk_veri_o, hk_blk_son_o);
        end
    end

    // Reference: raster-domain block walked along zigzag order.
    task automatic build_expected();
        int L, r;
        logic [11:0] v;
        for (int i = 0; i < 64; i++) vals[i] = '0;
        foreach (beats_q[i]) vals[int'(beats_q[i].row) * 8 + int'(beats_q[i].col)] = beats_q[i].veri;
        L = 0;
        for (int k = 1; k < 64; k++) if (vals[order[k]] != 0) L = k;
        exp_L = L;
        exp_q.push_back(mk(4'd0, vals[order[0]], 1'b0));
        r = 0;
        for (int k = 1; k <= L; k++) begin
            v = vals[order[k]];
            if (v != 0) begin
                exp_q.push_back(mk(4'(r), v, k == 63));
                r = 0;
            end else if (r == 15) begin
                exp_q.push_back(mk(4'd15, 12'd0, 1'b0));
                r = 0;
            end else r++;
        end
        if (L < 63) exp_q.push_back(mk(4'd0, 12'd0, 1'b1));
    endtask

    task automatic send_block(input bit wait_done, input bit gaps);
        int n;
        int t;
        build_expected();
        n = beats_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    q_gecerli_i = 1'b0;
                    @(negedge clk_i);
                end
            end
            q_row_i = beats_q[i].row;
            q_col_i = beats_q[i].col;
            q_veri_i = beats_q[i].veri;
            q_gecerli_i = 1'b1;
            q_blok_son_i = (i == n - 1);
            @(posedge clk_i);
            #1;
            if (i == n - 1) begin n_edge = cyc; busy = 1; end
        end
        q_gecerli_i = 1'b0;
        q_blok_son_i = 1'b0;
        if (wait_done) begin
            t = 0;
            while (busy && t < 3000) begin @(posedge clk_i); t++; end
            chk("block_done", {31'd0, busy}, 32'd0);
            chk("queue_empty", exp_q.size(), 32'd0);
            @(negedge clk_i);
        end
    endtask

    function automatic logic [11:0] rnd_nz();
        logic [11:0] v;
        do v = 12'($urandom); while (v == 0);
        return v;
    endfunction

    task automatic add(input int row, input int col, input int v);
        beats_q.push_back({3'(row), 3'(col), 12'(v)});
    endtask

    task automatic case2();
        beats_q.delete(); add(0, 1, 3); add(2, 0, -1); add(0, 0, 10);
    endtask

    initial begin
        int n;
        n = 0;
        for (int d = 0; d < 15; d++) begin
            if (d % 2 == 0) begin
                for (int r = 7; r >= 0; r--) if (d - r >= 0 && d - r < 8) order[n++] = r * 8 + (d - r);
            end else begin
                for (int r = 0; r < 8; r++) if (d - r >= 0 && d - r < 8) order[n++] = r * 8 + (d - r);
            end
        end

        repeat (2) @(negedge clk_i);
        chk("rst_gecerli", {31'd0, hk_gecerli_o}, 32'd0);
        chk("rst_run", {28'd0, hk_run_o}, 32'd0);
        chk("rst_veri", {20'd0, hk_veri_o}, 32'd0);
        chk("rst_son", {31'd0, hk_blk_son_o}, 32'd0);
        chk("rst_hazir_low", {31'd0, q_hazir_o}, 32'd0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rst_hazir_high", {31'd0, q_hazir_o}, 32'd1);
        mon_en = 1;

        timing_chk = 1; stall_mode = 0;
        beats_q.delete(); add(0, 0, -5);               send_block(1, 0);
        case2();                                       send_block(1, 0);
        beats_q.delete(); add(3, 5, 7); add(0, 0, 0);  send_block(1, 0);
        beats_q.delete(); add(7, 7, 1); add(0, 0, 2);  send_block(1, 0);
        beats_q.delete(); add(1, 1, 5); add(0, 0, 1); add(1, 1, 0); send_block(1, 0);

        timing_chk = 0; stall_mode = 1;
        case2();                                       send_block(1, 0);
        stall_mode = 0;

        // Reset pulse in the middle of a scan.
        beats_q.delete(); add(3, 5, 7); add(0, 0, 0);  send_block(0, 0);
        repeat (10) @(posedge clk_i);
        mon_en = 0;
        #2 rstn_i = 1'b0;
        #1;
        chk("midrst_gecerli", {31'd0, hk_gecerli_o}, 32'd0);
        chk("midrst_run", {28'd0, hk_run_o}, 32'd0);
        chk("midrst_veri", {20'd0, hk_veri_o}, 32'd0);
        chk("midrst_son", {31'd0, hk_blk_son_o}, 32'd0);
        exp_q.delete(); busy = 0; clr_pending = 0; prev_stalled = 0;
        @(posedge clk_i);
        #2 rstn_i = 1'b1;
        mon_en = 1;
        timing_chk = 1;
        case2();                                       send_block(1, 0);

        // Randomized blocks, including repeated positions and stalls.
        for (int b = 0; b < 24; b++) begin
            beats_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++)
                add($urandom_range(0, 7), $urandom_range(0, 7),
                    ($urandom_range(0, 2) == 0) ? 0 : int'(rnd_nz()));
            stall_mode = (b >= 12) ? 2 : 0;
            timing_chk = (stall_mode == 0);
            send_block(1, 1);
        end
        stall_mode = 0; timing_chk = 1;
        beats_q.delete();
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) add(r, c, int'(rnd_nz()));
        send_block(1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
